spi_slave_multichannel: RTL
===========================

# spi_slave_multichannel

Parametrised SPI peripheral that receives a frame of CHANNELS words of DATA_WIDTH bits from the SPI master and returns a snapshot of CHANNELS status words in the same frame. It is the next-generation replacement for the fixed two-channel, 16-bit, mode-0 SPI slave that carries pitch/yaw commands and feedback. It sits between the external SPI pins and the actuator/sensor logic in the system-clock domain. It adds selectable SPI mode, input synchronisation, frame-length checking and a commit strobe.

## Interface
- CHANNELS, 2, number of words per frame (≥1)
- DATA_WIDTH, 16, bits per word (≥2)
- CPOL, 0, SPI_CLK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- SYNC_STAGES, 2, synchroniser depth for SPI_CLK/SPI_PICO/SPI_CS (≥2)
- Derived: FRAME_BITS = CHANNELS*DATA_WIDTH; word 0 occupies bits [FRAME_BITS-1 -: DATA_WIDTH]
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- SPI_CLK  in  1  master serial clock (asynchronous to clk)
- SPI_PICO  in  1  master-out data, MSB first
- SPI_CS  in  1  chip select, active low
- SPI_POCI  out  1  slave-out data, MSB first
- tx_data  in  FRAME_BITS  words returned to master, word 0 in MSBs
- rx_data  out  FRAME_BITS  last valid received frame, word 0 in MSBs
- rx_valid  out  1  one-cycle pulse when rx_data updates
- frame_error  out  1  one-cycle pulse when a frame ends with a bit count ≠ FRAME_BITS
- busy  out  1  high while in ACTIVE

## Operation
- All three SPI inputs pass through SYNC_STAGES flops. Edge detection uses the last synchronised stage against one extra delay flop.
- Leading edge = SPI_CLK leaving the CPOL level; trailing edge = returning to it.
- FSM states:
  - WAIT_IDLE: reset state. Goes to IDLE when synced CS is high.
  - IDLE: goes to ACTIVE on synced CS falling edge.
  - ACTIVE: goes to IDLE on synced CS rising edge.
- WAIT_IDLE ensures a frame already in progress at reset release is ignored entirely.
- On the IDLE→ACTIVE transition:
  - tx_data is snapshotted into tx_shift.
  - bit_cnt clears.
  - rx_shift clears.
- CPHA=0:
  - SPI_POCI = tx_shift MSB from entry to ACTIVE.
  - Leading edge: rx_shift ← {rx_shift, PICO}, bit_cnt++.
  - Trailing edge: tx_shift shifts left.
- CPHA=1:
  - Leading edge: SPI_POCI takes the next tx bit. The first leading edge presents the MSB and does not shift it away.
  - Trailing edge: samples PICO, bit_cnt++.
- bit_cnt saturates at FRAME_BITS+1. The receive shift register stops after FRAME_BITS samples.
- On the ACTIVE→IDLE transition:
  - If bit_cnt == FRAME_BITS: rx_data ← rx_shift and rx_valid pulses.
  - Otherwise: frame_error pulses and rx_data holds its previous value.
- tx_data changes during ACTIVE have no effect on the current frame.
- SPI_POCI is driven 0 outside ACTIVE. Bits beyond FRAME_BITS are 0.
- A clock edge and a CS rising edge detected in the same cycle: CS wins, the edge is ignored.

## Timing
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_error = 0, busy = 0, SPI_POCI = 0.
  - State = WAIT_IDLE; all shift registers and counters are 0.
- Assertion of rst_n mid-frame clears everything immediately. No rx_valid or frame_error is produced for that frame.
- Input latency: SYNC_STAGES+1 clk cycles from pin to detected edge.
- rx_valid and frame_error rise SYNC_STAGES+2 clk cycles after the SPI_CS pin rises, each high for exactly 1 cycle. They are mutually exclusive.
- rx_data is stable from the cycle rx_valid is high until the next rx_valid.
- busy rises SYNC_STAGES+2 cycles after the CS pin falls and falls in the same cycle rx_valid/frame_error is produced.
- SPI_POCI changes within SYNC_STAGES+2 clk cycles of the shifting SPI_CLK edge.
- Constraints on the master:
  - SPI_CLK period ≥ 10 clk periods, half-period ≥ SYNC_STAGES+3 clk periods.
  - CS setup to the first edge and CS hold after the last edge ≥ one SPI half-period.
  - CS high time between frames ≥ SYNC_STAGES+3 clk periods.
- Back-to-back frames meeting these constraints are each committed independently.

## Test plan
- Defaults, mode 0, tx_data=0xDEADBEEF, master sends 0xBEEFDEAD → master reads 0xDEADBEEF; rx_data=0xBEEFDEAD; exactly one rx_valid pulse; frame_error never high.
- Short frame of 24 bits, then a long frame of 40 bits, after a good frame of 0x12345678 → frame_error pulses once per bad frame; rx_data stays 0x12345678; rx_valid stays low.
- CHANNELS=3, DATA_WIDTH=12, CPOL=1, CPHA=1, tx_data=0xABC123456, master sends 0x0FF00F5A5 → master reads 0xABC123456; rx_data=0x0FF00F5A5; one rx_valid.
- tx_data changed from 0xDEADBEEF to 0x00000000 after bit 8 of a mode-0 frame → master still reads 0xDEADBEEF; the next frame reads 0x00000000.
- rst_n asserted after bit 10, released while CS is still low, frame completes → no rx_valid/frame_error; rx_data=0. The following full frame 0xCAFEF00D commits normally.
- Two back-to-back frames 0x11112222 and 0x33334444 with minimum CS gap → two rx_valid pulses with rx_data 0x11112222 then 0x33334444; busy low between them.

Source files
------------

// File: rtl/spi_slave_multichannel.sv
// SPI peripheral: one frame of CHANNELS x DATA_WIDTH words in, status snapshot out.
// SPI pins are synchronised into clk; frames commit only on an exact bit count.
module spi_slave_multichannel #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2,
    localparam int FRAME_BITS = CHANNELS * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SPI_CLK,
    input  logic                  SPI_PICO,
    input  logic                  SPI_CS,
    output logic                  SPI_POCI,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, pico_sync, cs_sync;
    logic                   clk_d, cs_d;
    logic                   clk_s, pico_s, cs_s;
    logic                   clk_rise, clk_fall, lead, trail;
    logic                   cs_rise, cs_fall;

    logic [FRAME_BITS-1:0]  tx_shift, rx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   first;

    logic                   load, sample_en, shift_en, lead_en;
    logic                   commit, abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '0;
            pico_sync <= '0;
            cs_sync   <= '0;
            clk_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
            pico_sync <= {pico_sync[SYNC_STAGES-2:0], SPI_PICO};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            clk_d     <= clk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign pico_s   = pico_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_d;
    assign clk_fall = ~clk_s & clk_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign lead     = (CPOL != 0) ? clk_fall : clk_rise;
    assign trail    = (CPOL != 0) ? clk_rise : clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_IDLE: if (cs_s)    state_nxt = IDLE;
            IDLE:      if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:    if (cs_rise) state_nxt = IDLE;
            default:                state_nxt = WAIT_IDLE;
        endcase
    end

    // A CS rising edge masks any clock edge seen in the same cycle.
    always_comb begin
        load      = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        lead_en   = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: load = cs_fall;
            ACTIVE: begin
                busy = 1'b1;
                if (cs_rise) begin
                    if (bit_cnt == CNT_FULL) commit = 1'b1;
                    else                     abort  = 1'b1;
                end else begin
                    lead_en   = lead;
                    sample_en = (CPHA != 0) ? trail : lead;
                    shift_en  = (CPHA != 0) ? (lead & ~first) : trail;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            first       <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            if (load) begin
                tx_shift <= tx_data;
                rx_shift <= '0;
                bit_cnt  <= '0;
                first    <= 1'b1;
            end
            if (sample_en) begin
                if (bit_cnt < CNT_FULL)
                    rx_shift <= {rx_shift[FRAME_BITS-2:0], pico_s};
                if (bit_cnt != CNT_MAX)
                    bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) tx_shift <= tx_shift << 1;
            if (lead_en)  first    <= 1'b0;
            if (commit) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
            if (abort) frame_error <= 1'b1;
        end
    end

    assign SPI_POCI = busy & tx_shift[FRAME_BITS-1];

endmodule
